// File: rtl/adpll_pi_filter_gear.sv
// Gear-shifted PI loop filter for the ADPLL: saturating integrator,
// saturating DCO code and an acquire/track lock detector.
module adpll_pi_filter_gear #(
  parameter bit DYNAMIC_VAL = 1'b0,
  parameter int ERROR_WIDTH = 8,
  parameter int DCO_CC_WIDTH = 9,
  parameter int KP_WIDTH = 4,
  parameter int KP_FRAC_WIDTH = 2,
  parameter int KI_WIDTH = 6,
  parameter int KI_FRAC_WIDTH = 4,
  parameter int ACC_WIDTH = 16,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 4'b1000,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 6'b010000,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 4'b0010,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 6'b000100,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT = 16,
  parameter int UNLOCK_THRESH = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic                           error_valid_i,
  input  logic                           freeze_i,
  input  logic                           clear_i,
  input  logic [KP_WIDTH-1:0]            kp_acq_i,
  input  logic [KI_WIDTH-1:0]            ki_acq_i,
  input  logic [KP_WIDTH-1:0]            kp_trk_i,
  input  logic [KI_WIDTH-1:0]            ki_trk_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           locked_o,
  output logic                           sat_o
);

  localparam int EW  = ERROR_WIDTH;
  localparam int EW1 = EW + 1;
  localparam int DW  = DCO_CC_WIDTH;
  localparam int AW  = ACC_WIDTH;
  localparam int SH  = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
  localparam int PW  = EW + KP_WIDTH + 1;
  localparam int IW  = EW + KI_WIDTH + 1;
  localparam int AW2 = ((AW > IW) ? AW : IW) + 1;
  localparam int SW  = (((PW + SH) > AW) ? (PW + SH) : AW) + 1;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int UCW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [0:0] ST_ACQ = 1'b0;
  localparam logic [0:0] ST_TRK = 1'b1;

  localparam logic [EW:0] LK_TH = EW1'(LOCK_THRESH);
  localparam logic [EW:0] UL_TH = EW1'(UNLOCK_THRESH);
  localparam logic [LCW-1:0] LK_MAX = LCW'(LOCK_COUNT);
  localparam logic [UCW-1:0] UL_MAX = UCW'(UNLOCK_COUNT);

  logic [0:0]             r_state;
  logic signed [AW-1:0]   r_acc;
  logic [LCW-1:0]         r_lk;
  logic [UCW-1:0]         r_ul;
  logic signed [DW-1:0]   r_dco;
  logic                   r_vld;
  logic                   r_sat;

  logic [KP_WIDTH-1:0]    w_kp;
  logic [KI_WIDTH-1:0]    w_ki;
  logic signed [PW-1:0]   w_p;
  logic signed [IW-1:0]   w_iterm;
  logic signed [AW2-1:0]  w_acc_sum;
  logic [AW2-AW:0]        w_acc_top;
  logic                   w_acc_ovf;
  logic signed [AW-1:0]   w_acc_upd;
  logic signed [AW-1:0]   w_acc_eff;
  logic                   w_acc_sat;
  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_shr;
  logic [SW-DW:0]         w_dco_top;
  logic                   w_dco_ovf;
  logic signed [DW-1:0]   w_dco;

  logic signed [EW:0]     w_e_ext;
  logic [EW:0]            w_abs;
  logic                   w_in_lk;
  logic                   w_out_lk;
  logic [LCW-1:0]         w_lk_inc;
  logic [UCW-1:0]         w_ul_inc;
  logic [LCW-1:0]         w_lk_pre;
  logic [UCW-1:0]         w_ul_pre;
  logic                   w_go_trk;
  logic                   w_go_acq;
  logic [0:0]             w_state_nxt;
  logic [LCW-1:0]         w_lk_nxt;
  logic [UCW-1:0]         w_ul_nxt;

  always_comb begin
    w_kp = DYNAMIC_VAL ? kp_acq_i : KP_ACQ;
    w_ki = DYNAMIC_VAL ? ki_acq_i : KI_ACQ;
    if (r_state == ST_TRK) begin
      w_kp = DYNAMIC_VAL ? kp_trk_i : KP_TRK;
      w_ki = DYNAMIC_VAL ? ki_trk_i : KI_TRK;
    end
  end

  assign w_p = PW'(error_i) * PW'($signed({1'b0, w_kp}));
  assign w_iterm = IW'(error_i) * IW'($signed({1'b0, w_ki}));

  // Fits in AW bits only if all bits from the AW-1 sign bit up agree.
  assign w_acc_sum = AW2'(r_acc) + AW2'(w_iterm);
  assign w_acc_top = w_acc_sum[AW2-1:AW-1];
  assign w_acc_ovf = !((&w_acc_top) || !(|w_acc_top));
  assign w_acc_upd = !w_acc_ovf ? w_acc_sum[AW-1:0] :
                     w_acc_sum[AW2-1] ? {1'b1, {(AW-1){1'b0}}} :
                                        {1'b0, {(AW-1){1'b1}}};

  always_comb begin
    w_acc_eff = w_acc_upd;
    if (clear_i) begin
      w_acc_eff = '0;
    end else if (freeze_i) begin
      w_acc_eff = r_acc;
    end
  end

  assign w_acc_sat = w_acc_ovf && !clear_i && !freeze_i;

  assign w_sum = (SW'(w_p) <<< SH) + SW'(w_acc_eff);
  assign w_shr = w_sum >>> KI_FRAC_WIDTH;
  assign w_dco_top = w_shr[SW-1:DW-1];
  assign w_dco_ovf = !((&w_dco_top) || !(|w_dco_top));
  assign w_dco = !w_dco_ovf ? w_shr[DW-1:0] :
                 w_shr[SW-1] ? {1'b1, {(DW-1){1'b0}}} :
                               {1'b0, {(DW-1){1'b1}}};

  assign w_e_ext = {error_i[EW-1], error_i};
  assign w_abs = w_e_ext[EW] ? $unsigned(-w_e_ext) : $unsigned(w_e_ext);
  assign w_in_lk = (w_abs <= LK_TH);
  assign w_out_lk = (w_abs > UL_TH);

  assign w_lk_inc = (r_lk == LK_MAX) ? r_lk : r_lk + LCW'(1);
  assign w_ul_inc = (r_ul == UL_MAX) ? r_ul : r_ul + UCW'(1);
  assign w_lk_pre = w_in_lk ? w_lk_inc : '0;
  assign w_ul_pre = w_out_lk ? w_ul_inc : '0;
  assign w_go_trk = (r_state == ST_ACQ) && (w_lk_pre == LK_MAX);
  assign w_go_acq = (r_state == ST_TRK) && (w_ul_pre == UL_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_lk_nxt = w_lk_pre;
    w_ul_nxt = w_ul_pre;
    unique case (1'b1)
      w_go_trk: begin
        w_state_nxt = ST_TRK;
        w_lk_nxt = '0;
        w_ul_nxt = '0;
      end
      w_go_acq: begin
        w_state_nxt = ST_ACQ;
        w_lk_nxt = '0;
        w_ul_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_ACQ;
      r_acc <= '0;
      r_lk <= '0;
      r_ul <= '0;
      r_dco <= '0;
      r_vld <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_vld <= error_valid_i;
      if (clear_i) begin
        r_state <= ST_ACQ;
        r_acc <= '0;
        r_lk <= '0;
        r_ul <= '0;
      end else if (error_valid_i && !freeze_i) begin
        r_state <= w_state_nxt;
        r_acc <= w_acc_upd;
        r_lk <= w_lk_nxt;
        r_ul <= w_ul_nxt;
      end
      if (error_valid_i) begin
        r_dco <= w_dco;
        r_sat <= w_dco_ovf || w_acc_sat;
      end
    end
  end

  assign dco_cc_o = r_dco;
  assign dco_cc_valid_o = r_vld;
  assign locked_o = (r_state == ST_TRK);
  assign sat_o = r_sat;

endmodule

// File: tb/tb_adpll_pi_filter_gear.sv
// Directed bench for adpll_pi_filter_gear: vector table plus
// hand sequences for saturation and asynchronous reset.
module tb_adpll_pi_filter_gear;

  logic              gen_clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic signed [7:0] error_i = '0;
  logic              error_valid_i = 1'b0;
  logic              freeze_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [3:0]        kp_acq_i = '0;
  logic [5:0]        ki_acq_i = '0;
  logic [3:0]        kp_trk_i = '0;
  logic [5:0]        ki_trk_i = '0;
  logic signed [8:0] dco_cc_o;
  logic              dco_cc_valid_o;
  logic              locked_o;
  logic              sat_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit    rst;
    bit    v;
    bit    f;
    bit    c;
    int    e;
    int    dco;
    bit    vo;
    bit    lk;
    bit    st;
    string nm;
  } vec_t;

  vec_t tbl[$];

  adpll_pi_filter_gear dut (
    .gen_clk_i(gen_clk_i),
    .reset_i(reset_i),
    .error_i(error_i),
    .error_valid_i(error_valid_i),
    .freeze_i(freeze_i),
    .clear_i(clear_i),
    .kp_acq_i(kp_acq_i),
    .ki_acq_i(ki_acq_i),
    .kp_trk_i(kp_trk_i),
    .ki_trk_i(ki_trk_i),
    .dco_cc_o(dco_cc_o),
    .dco_cc_valid_o(dco_cc_valid_o),
    .locked_o(locked_o),
    .sat_o(sat_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  function automatic vec_t mk(bit rst, bit v, bit f, bit c,
                              int e, int dco, bit vo, bit lk,
                              bit st, string nm);
    vec_t t;
    t.rst = rst; t.v = v; t.f = f; t.c = c; t.e = e;
    t.dco = dco; t.vo = vo; t.lk = lk; t.st = st; t.nm = nm;
    return t;
  endfunction

  task automatic chk(string nm, int dco, bit vo, bit lk, bit st);
    n_cmp++;
    if (dco_cc_o !== 9'(dco) || dco_cc_valid_o !== vo ||
        locked_o !== lk || sat_o !== st) begin
      n_err++;
      $display("FAIL %s: got dco=%0d v=%0b l=%0b s=%0b want dco=%0d v=%0b l=%0b s=%0b",
               nm, dco_cc_o, dco_cc_valid_o, locked_o, sat_o,
               dco, vo, lk, st);
    end
  endtask

  task automatic do_reset();
    @(negedge gen_clk_i);
    error_valid_i = 1'b0;
    freeze_i = 1'b0;
    clear_i = 1'b0;
    reset_i = 1'b1;
    @(negedge gen_clk_i);
    reset_i = 1'b0;
  endtask

  task automatic step(int e, bit v, bit f, bit c);
    @(negedge gen_clk_i);
    error_i = 8'(e);
    error_valid_i = v;
    freeze_i = f;
    clear_i = c;
    @(posedge gen_clk_i);
    #1;
  endtask

  initial begin
    // basic sample and negative saturation
    tbl.push_back(mk(1,1,0,0,  10,  30,1,0,0,"first"));
    tbl.push_back(mk(1,1,0,0,-128,-256,1,0,1,"neg_sat"));
    // lock acquisition with gaps and threshold-edge samples
    tbl.push_back(mk(1,1,0,0,  10,  30,1,0,0,"lk_pre"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,0,0,"lk1"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,0,0,"lk2"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,0,0,"lk3"));
    tbl.push_back(mk(0,0,0,0,  77,  10,0,0,0,"gap1"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,0,0,"lk4"));
    tbl.push_back(mk(0,1,0,0,   2,  16,1,0,0,"lk5_p2"));
    tbl.push_back(mk(0,1,0,0,  -2,   6,1,0,0,"lk6_m2"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,0,0,"lk7"));
    tbl.push_back(mk(0,0,0,0, -90,  10,0,0,0,"gap2"));
    for (int i = 8; i <= 15; i++)
      tbl.push_back(mk(0,1,0,0, 0, 10,1,0,0,"lk8_15"));
    tbl.push_back(mk(0,1,0,0,   0,  10,1,1,0,"lk16"));
    tbl.push_back(mk(0,1,0,0,   4,  13,1,1,0,"trk_e4"));
    tbl.push_back(mk(0,1,0,0,   9,  17,1,1,0,"ul1"));
    tbl.push_back(mk(0,1,0,0,   9,  20,1,1,0,"ul2"));
    tbl.push_back(mk(0,1,0,0,   9,  22,1,1,0,"ul3"));
    tbl.push_back(mk(0,1,0,0,  -8,  11,1,1,0,"ul_m8"));
    tbl.push_back(mk(0,1,0,0,   9,  22,1,1,0,"ul1b"));
    tbl.push_back(mk(0,1,0,0,   9,  24,1,1,0,"ul2b"));
    tbl.push_back(mk(0,1,0,0,   9,  27,1,1,0,"ul3b"));
    tbl.push_back(mk(0,1,0,0,   9,  29,1,0,0,"ul4b"));
    tbl.push_back(mk(0,1,0,0,   1,  27,1,0,0,"acq_gear"));
    // freeze and clear
    tbl.push_back(mk(1,1,0,0,  10,  30,1,0,0,"fz1"));
    tbl.push_back(mk(0,1,0,0,  10,  40,1,0,0,"fz2"));
    tbl.push_back(mk(0,1,0,0,  10,  50,1,0,0,"fz3"));
    tbl.push_back(mk(0,1,0,0,  10,  60,1,0,0,"fz4"));
    tbl.push_back(mk(0,1,0,0,  10,  70,1,0,0,"fz5"));
    tbl.push_back(mk(0,1,1,0,  10,  70,1,0,0,"frz_a"));
    tbl.push_back(mk(0,1,1,0,  10,  70,1,0,0,"frz_b"));
    tbl.push_back(mk(0,1,0,0,  10,  80,1,0,0,"post_frz"));
    tbl.push_back(mk(0,1,0,1,  10,  20,1,0,0,"clr_v"));
    tbl.push_back(mk(0,1,0,0,  10,  30,1,0,0,"post_clr"));
    tbl.push_back(mk(0,1,0,0,  10,  40,1,0,0,"acc20"));
    tbl.push_back(mk(0,0,0,1,  10,  40,0,0,0,"clr_nov"));
    tbl.push_back(mk(0,1,0,0,  10,  30,1,0,0,"post_clr2"));
    tbl.push_back(mk(0,1,1,1,  10,  20,1,0,0,"clr_frz"));
    tbl.push_back(mk(0,1,0,0,  10,  30,1,0,0,"post_cf"));

    reset_i = 1'b1;
    #12;
    chk("reset", 0, 0, 0, 0);
    reset_i = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].e, tbl[i].v, tbl[i].f, tbl[i].c);
      chk(tbl[i].nm, tbl[i].dco, tbl[i].vo, tbl[i].lk, tbl[i].st);
    end

    // integrator pinned at 0x7FFF, then unwound by -100 steps
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      step(100, 1, 0, 0);
      chk("pos_sat", 255, 1, 0, 1);
    end
    for (int k = 1; k <= 15; k++) begin
      step(-100, 1, 0, 0);
      chk("unwind_sat", 255, 1, 0, 1);
    end
    step(-100, 1, 0, 0);
    chk("unwind_247", 247, 1, 0, 0);

    // asynchronous reset between edges
    do_reset();
    step(10, 1, 0, 0);
    step(20, 1, 0, 0);
    chk("pre_arst", 70, 1, 0, 0);
    @(posedge gen_clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_rst", 0, 0, 0, 0);
    @(negedge gen_clk_i);
    error_valid_i = 1'b0;
    reset_i = 1'b0;
    step(-3, 1, 0, 0);
    chk("after_arst", -9, 1, 0, 0);
    step(-128, 1, 0, 0);
    chk("after_arst_sat", -256, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
